// File: rtl/btn_pkg.sv
// Shared constants and types for the button select/debounce block.
package btn_pkg;

  // 10 ms at 100 MHz.
  localparam int unsigned DB_CYCLES_10MS = 1_000_000;
  // Short debounce window for simulation.
  localparam int unsigned DB_CYCLES_SIM  = 4;

  localparam int unsigned N_CH_DEFAULT   = 4;

  // Channel index for the default channel count.
  typedef logic [$clog2(N_CH_DEFAULT)-1:0] ch_idx_t;

  // Counter width able to hold 0..db.
  function automatic int unsigned cnt_width(int unsigned db);
    return $clog2(db + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-channel synchroniser plus stable-count debouncer.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_10MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned     CNT_W    = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;

  // Synchroniser chain: raw enters at bit 0, s is the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Count consecutive samples that disagree with the level; any agreement restarts.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/btn_select_debounce.sv
// N-channel debounced buttons with a registered runtime channel select,
// producing a clean level and a single-cycle press pulse for the selected channel.
module btn_select_debounce
  import btn_pkg::*;
#(
  parameter  int unsigned N_CH        = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned DB_CYCLES   = DB_CYCLES_10MS,
  localparam int unsigned SEL_W       = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  btn_in,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_load,
  output logic [SEL_W-1:0] cur_sel,
  output logic [N_CH-1:0]  btn_level,
  output logic             out,
  output logic             out_press
);

  // One extra bit so N_CH itself is representable for the range check.
  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(N_CH);

  logic [SEL_W-1:0] cur_sel_q;
  logic [N_CH-1:0]  lvl_d_q;
  logic [N_CH-1:0]  rise;
  logic             out_q, press_q;
  logic             sel_ok;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_in[i]),
      .level (btn_level[i])
    );
  end

  assign rise   = btn_level & ~lvl_d_q;
  assign sel_ok = ({1'b0, sel} < CH_LIMIT);

  // Select, edge history and output registers; outputs use cur_sel before any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel_q <= '0;
      lvl_d_q   <= '0;
      out_q     <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      lvl_d_q <= btn_level;
      out_q   <= btn_level[cur_sel_q];
      press_q <= rise[cur_sel_q];
      if (sel_load && sel_ok) begin
        cur_sel_q <= sel;
      end
    end
  end

  assign cur_sel   = cur_sel_q;
  assign out       = out_q;
  assign out_press = press_q;

endmodule
